// File: rtl/write_back_unit_pkg.sv
// Shared widths and the result-buffer entry layout for the write-back stage.
// Entry fields: destination, result data, load flag, data-present flag.
package write_back_unit_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 4;
  localparam int WB_DEPTH = 2;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef struct packed {
    reg_idx_t  dest;
    reg_data_t data;
    logic      is_load;
    logic      data_ok;
  } wb_entry_t;

  typedef struct packed {
    logic      busy;
    logic      fwd_valid;
    reg_data_t fwd_data;
  } fwd_view_t;

  // Loads carry no data until their memory response arrives at retire.
  function automatic wb_entry_t make_entry(reg_idx_t dest, reg_data_t data, logic is_load);
    wb_entry_t e;
    e.dest    = dest;
    e.data    = is_load ? '0 : data;
    e.is_load = is_load;
    e.data_ok = !is_load;
    return e;
  endfunction

endpackage

// File: rtl/write_back_unit_if.sv
// Execute, memory-response, register-file write and operand-fetch signals of the write-back stage.
// slave = write-back unit side, master = surrounding pipeline side.
interface write_back_unit_if;
  import write_back_unit_pkg::*;

  logic      ex_valid;
  logic      ex_ready;
  logic      ex_wen;
  logic      ex_is_load;
  reg_idx_t  ex_dest;
  reg_data_t ex_data;

  logic      mem_rsp_valid;
  reg_data_t mem_rsp_data;

  reg_idx_t  write_port_address;
  reg_data_t write_data;
  logic      is_write;

  reg_idx_t  of_src1;
  reg_idx_t  of_src2;
  logic      src1_busy;
  logic      src1_fwd_valid;
  reg_data_t src1_fwd_data;
  logic      src2_busy;
  logic      src2_fwd_valid;
  reg_data_t src2_fwd_data;

  logic      rsp_unexpected;

  modport slave (
    input  ex_valid, ex_wen, ex_is_load, ex_dest, ex_data,
    input  mem_rsp_valid, mem_rsp_data,
    input  of_src1, of_src2,
    output ex_ready,
    output write_port_address, write_data, is_write,
    output src1_busy, src1_fwd_valid, src1_fwd_data,
    output src2_busy, src2_fwd_valid, src2_fwd_data,
    output rsp_unexpected
  );

  modport master (
    output ex_valid, ex_wen, ex_is_load, ex_dest, ex_data,
    output mem_rsp_valid, mem_rsp_data,
    output of_src1, of_src2,
    input  ex_ready,
    input  write_port_address, write_data, is_write,
    input  src1_busy, src1_fwd_valid, src1_fwd_data,
    input  src2_busy, src2_fwd_valid, src2_fwd_data,
    input  rsp_unexpected
  );

endinterface

// File: rtl/write_back_unit_wb_fifo.sv
// Circular result buffer; push/pop take effect at the clock edge, head visible the cycle after push.
// Push while full and pop while empty are ignored; entries exposed oldest-first for forwarding.
module wb_fifo
  import write_back_unit_pkg::*;
#(
  parameter  int DEPTH = WB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  wb_entry_t              i_push_entry,
  input  logic                   i_pop,
  output wb_entry_t              o_head,
  output logic [CNT_W-1:0]       o_count,
  output logic                   o_full,
  output logic                   o_empty,
  output wb_entry_t [DEPTH-1:0]  o_entries,
  output logic      [DEPTH-1:0]  o_entry_vld
);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_head];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_tail <= r_tail + 1'b1;
      if (w_pop_ok)  r_head <= r_head + 1'b1;
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
    end
  end

  // Storage needs no reset: validity is tracked by the count alone.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_tail] <= i_push_entry;
  end

  always_comb begin
    o_entries   = '0;
    o_entry_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_entries[i]   = r_mem[r_head + PTR_W'(i)];
      o_entry_vld[i] = (CNT_W'(i) < r_count);
    end
  end

endmodule

// File: rtl/write_back_unit.sv
// In-order retire of buffered execute results to the register file; 2 cycles ex_valid -> is_write.
// ex_ready drops only for writing instructions when the buffer is full; loads stall at head for data.
module write_back_unit
  import write_back_unit_pkg::*;
#(
  parameter  int DEPTH = WB_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  write_back_unit_if.slave  wb
);

  wb_entry_t             w_head;
  wb_entry_t [DEPTH-1:0] w_entries;
  logic      [DEPTH-1:0] w_entry_vld;
  logic      [CNT_W-1:0] w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_retire;
  fwd_view_t             w_fwd1;
  fwd_view_t             w_fwd2;

  logic                  r_is_write;
  reg_idx_t              r_wr_addr;
  reg_data_t             r_wr_data;
  logic                  r_rsp_unexpected;

  assign wb.ex_ready = !w_full || !wb.ex_wen;
  assign w_push      = wb.ex_valid && wb.ex_ready && wb.ex_wen;
  assign w_retire    = !w_empty && (w_head.data_ok || wb.mem_rsp_valid);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_push       (w_push),
    .i_push_entry (make_entry(wb.ex_dest, wb.ex_data, wb.ex_is_load)),
    .i_pop        (w_retire),
    .o_head       (w_head),
    .o_count      (w_count),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_entries    (w_entries),
    .o_entry_vld  (w_entry_vld)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_is_write       <= 1'b0;
      r_wr_addr        <= '0;
      r_wr_data        <= '0;
      r_rsp_unexpected <= 1'b0;
    end else begin
      r_is_write <= w_retire;
      if (w_retire) begin
        r_wr_addr <= w_head.dest;
        r_wr_data <= w_head.data_ok ? w_head.data : wb.mem_rsp_data;
      end
      r_rsp_unexpected <= wb.mem_rsp_valid && (w_empty || !w_head.is_load);
    end
  end

  // Scan oldest to youngest so the last match (the youngest writer) wins.
  function automatic fwd_view_t fwd_lookup(reg_idx_t src, logic out_vld, reg_idx_t out_addr,
                                           reg_data_t out_data, wb_entry_t [DEPTH-1:0] ents,
                                           logic [DEPTH-1:0] vld);
    fwd_view_t v;
    v = '0;
    if (out_vld && (out_addr == src)) begin
      v.fwd_valid = 1'b1;
      v.fwd_data  = out_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (ents[i].dest == src)) begin
        v.busy      = !ents[i].data_ok;
        v.fwd_valid = ents[i].data_ok;
        v.fwd_data  = ents[i].data_ok ? ents[i].data : '0;
      end
    end
    return v;
  endfunction

  always_comb begin
    w_fwd1 = fwd_lookup(wb.of_src1, r_is_write, r_wr_addr, r_wr_data, w_entries, w_entry_vld);
    w_fwd2 = fwd_lookup(wb.of_src2, r_is_write, r_wr_addr, r_wr_data, w_entries, w_entry_vld);
  end

  assign wb.write_port_address = r_wr_addr;
  assign wb.write_data         = r_wr_data;
  assign wb.is_write           = r_is_write;
  assign wb.rsp_unexpected     = r_rsp_unexpected;
  assign wb.src1_busy          = w_fwd1.busy;
  assign wb.src1_fwd_valid     = w_fwd1.fwd_valid;
  assign wb.src1_fwd_data      = w_fwd1.fwd_data;
  assign wb.src2_busy          = w_fwd2.busy;
  assign wb.src2_fwd_valid     = w_fwd2.fwd_valid;
  assign wb.src2_fwd_data      = w_fwd2.fwd_data;

  // Count is only needed inside the buffer; tie it off here to keep the port explicit.
  logic w_count_unused;
  assign w_count_unused = ^w_count;

endmodule

// File: tb/tb_write_back_unit.sv
// Directed bench for write_back_unit: latency, load ordering, forwarding, backpressure, reset.
module tb_write_back_unit;
  import write_back_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  write_back_unit_if wb();

  write_back_unit #(.DEPTH(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .wb    (wb)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic wen, input logic is_load, input logic [3:0] dest,
                      input logic [63:0] data);
    wb.ex_valid   = 1'b1;
    wb.ex_wen     = wen;
    wb.ex_is_load = is_load;
    wb.ex_dest    = dest;
    wb.ex_data    = data;
    tick();
    wb.ex_valid   = 1'b0;
  endtask

  task automatic mem_rsp(input logic [63:0] data);
    wb.mem_rsp_valid = 1'b1;
    wb.mem_rsp_data  = data;
    tick();
    wb.mem_rsp_valid = 1'b0;
  endtask

  initial begin
    wb.ex_valid = 0; wb.ex_wen = 0; wb.ex_is_load = 0; wb.ex_dest = '0; wb.ex_data = '0;
    wb.mem_rsp_valid = 0; wb.mem_rsp_data = '0; wb.of_src1 = '0; wb.of_src2 = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    wb.ex_wen = 1'b1; #1;
    check("rst_is_write", wb.is_write, 0);
    check("rst_addr", wb.write_port_address, 0);
    check("rst_data", wb.write_data, 0);
    check("rst_unexp", wb.rsp_unexpected, 0);
    check("rst_ready", wb.ex_ready, 1);
    check("rst_busy1", wb.src1_busy, 0);
    check("rst_fwd1", wb.src1_fwd_valid, 0);

    // 1: ALU result reaches the write port two edges after acceptance, for one cycle
    send(1, 0, 3, 64'hAA);
    check("t1_early", wb.is_write, 0);
    tick();
    check("t1_wr", wb.is_write, 1);
    check("t1_addr", wb.write_port_address, 3);
    check("t1_data", wb.write_data, 64'hAA);
    tick();
    check("t1_one_cycle", wb.is_write, 0);

    // 2: two loads fill the buffer and retire in order on their responses
    send(1, 1, 1, 64'hDEAD);
    send(1, 1, 2, 64'hBEEF);
    wb.ex_wen = 1'b1; wb.of_src1 = 1; wb.of_src2 = 2; #1;
    check("t2_full_ready", wb.ex_ready, 0);
    check("t2_busy1", wb.src1_busy, 1);
    check("t2_fwdv1", wb.src1_fwd_valid, 0);
    check("t2_busy2", wb.src2_busy, 1);
    tick();
    check("t2_stall", wb.is_write, 0);
    mem_rsp(64'h11);
    check("t2_wr1", wb.is_write, 1);
    check("t2_addr1", wb.write_port_address, 1);
    check("t2_data1", wb.write_data, 64'h11);
    check("t2_ready", wb.ex_ready, 1);
    check("t2_fwd1_out", wb.src1_fwd_data, 64'h11);
    check("t2_busy2b", wb.src2_busy, 1);
    mem_rsp(64'h22);
    check("t2_wr2", wb.is_write, 1);
    check("t2_addr2", wb.write_port_address, 2);
    check("t2_data2", wb.write_data, 64'h22);
    check("t2_unexp", wb.rsp_unexpected, 0);
    tick();
    check("t2_idle", wb.is_write, 0);

    // 3: two pending writers of r5; the younger value is forwarded
    wb.of_src1 = 5;
    send(1, 0, 5, 64'h1);
    check("t3_fwd_old", wb.src1_fwd_data, 64'h1);
    send(1, 0, 5, 64'h2);
    check("t3_out_old", wb.write_data, 64'h1);
    check("t3_fwdv", wb.src1_fwd_valid, 1);
    check("t3_fwd_young", wb.src1_fwd_data, 64'h2);
    tick();
    check("t3_out_young", wb.write_data, 64'h2);
    check("t3_fwd_out", wb.src1_fwd_data, 64'h2);
    tick();
    check("t3_none_v", wb.src1_fwd_valid, 0);
    check("t3_none_d", wb.src1_fwd_data, 0);

    // 4: non-writing instruction passes a full buffer without occupying it
    send(1, 1, 7, 64'h0);
    send(1, 1, 8, 64'h0);
    wb.ex_valid = 1'b1; wb.ex_wen = 1'b0; #1;
    check("t4_nowen_ready", wb.ex_ready, 1);
    tick();
    wb.ex_valid = 1'b0;
    check("t4_no_write", wb.is_write, 0);
    wb.ex_wen = 1'b1; wb.of_src1 = 8; #1;
    check("t4_still_full", wb.ex_ready, 0);
    check("t4_busy8", wb.src1_busy, 1);
    mem_rsp(64'h77);
    check("t4_addr7", wb.write_port_address, 7);
    mem_rsp(64'h88);
    check("t4_addr8", wb.write_port_address, 8);
    check("t4_data8", wb.write_data, 64'h88);
    tick();

    // 5: response with nothing waiting
    mem_rsp(64'h55);
    check("t5_unexp", wb.rsp_unexpected, 1);
    check("t5_no_write", wb.is_write, 0);
    tick();
    check("t5_pulse", wb.rsp_unexpected, 0);

    // 6: reset discards the output stage and a pending load
    wb.of_src1 = 9; wb.of_src2 = 4;
    send(1, 0, 4, 64'h44);
    send(1, 1, 9, 64'h0);
    check("t6_pre_wr", wb.is_write, 1);
    check("t6_pre_fwd4", wb.src2_fwd_valid, 1);
    check("t6_pre_busy9", wb.src1_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_wr", wb.is_write, 0);
    check("t6_addr", wb.write_port_address, 0);
    check("t6_busy9", wb.src1_busy, 0);
    check("t6_fwd4", wb.src2_fwd_valid, 0);
    check("t6_count", dut.u_fifo.r_count, 0);
    mem_rsp(64'h99);
    check("t6_unexp", wb.rsp_unexpected, 1);
    check("t6_no_write", wb.is_write, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
